// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the sensor controller state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_128     = 3'b100;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR1,
    ERR2
  } ctrl_state_t;

endpackage

// File: rtl/ahb_sensor_ctrl_if.sv
// AHB-Lite slave bus plus the req/ack sensor backend, bundled for the controller.
//
// Handshakes:
//  - AHB: an address phase is accepted on a HCLK edge where HSELx & HREADY &
//    HTRANS[1] are high and the slave is not mid data phase; the data phase
//    ends on the edge where HREADYOUT is high.
//  - Backend: be_req rises with be_write/be_addr/be_wdata valid and stays
//    high until the edge where be_ack is seen; be_ack is a one-cycle pulse
//    carrying be_rdata. be_ack while be_req is low is ignored.
interface ahb_sensor_ctrl_if #(
  parameter int DATA_W = 128
);

  logic              HSELx;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic              HREADY;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  logic              be_req;
  logic              be_write;
  logic [7:0]        be_addr;
  logic [DATA_W-1:0] be_wdata;
  logic              be_ack;
  logic [DATA_W-1:0] be_rdata;

  modport slave (
    input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY, HWDATA,
    input  be_ack, be_rdata,
    output HRDATA, HREADYOUT, HRESP,
    output be_req, be_write, be_addr, be_wdata
  );

  modport master (
    output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY, HWDATA,
    output be_ack, be_rdata,
    input  HRDATA, HREADYOUT, HRESP,
    input  be_req, be_write, be_addr, be_wdata
  );

endinterface

// File: rtl/ahb_xfer_check.sv
// Combinational address-phase qualifier: is a transfer being started, and is it one we serve.
module ahb_xfer_check
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hF0F0_F0F0,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00
) (
  input  logic        sel,
  input  logic        ready,
  input  logic [1:0]  trans,
  input  logic [2:0]  size,
  input  logic [2:0]  burst,
  input  logic [31:0] addr,
  output logic        xfer_start,
  output logic        xfer_valid
);

  // NONSEQ and SEQ both start a transfer; only a single 128-bit NONSEQ inside our window is served.
  always_comb begin
    xfer_start = sel & ready & trans[1];
    xfer_valid = ((addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) &&
                 (burst == HBURST_SINGLE) &&
                 (size == HSIZE_128) &&
                 (trans == HTRANS_NONSEQ);
  end

endmodule

// File: rtl/ahb_sensor_ctrl.sv
// AHB-Lite slave data-phase sequencer for the sensor backend: wait states, ERROR and timeout.
module ahb_sensor_ctrl
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hF0F0_F0F0,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
  parameter int          DATA_W    = 128,
  parameter int          TIMEOUT   = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  ahb_sensor_ctrl_if.slave bus,
  output ctrl_state_t state
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic             xfer_start;
  logic             xfer_valid;
  logic [CNT_W-1:0] cnt;

  ahb_xfer_check #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_MASK (ADDR_MASK)
  ) u_check (
    .sel        (bus.HSELx),
    .ready      (bus.HREADY),
    .trans      (bus.HTRANS),
    .size       (bus.HSIZE),
    .burst      (bus.HBURST),
    .addr       (bus.HADDR),
    .xfer_start (xfer_start),
    .xfer_valid (xfer_valid)
  );

  // Write data is forwarded straight from the AHB data phase.
  assign bus.be_wdata = bus.HWDATA;

  // Controller FSM with registered bus/backend outputs; outputs always reflect the state being entered.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state         <= IDLE;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= HRESP_OKAY;
      bus.HRDATA    <= {DATA_W{1'b0}};
      bus.be_req    <= 1'b0;
      bus.be_write  <= 1'b0;
      bus.be_addr   <= 8'h00;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR2: begin
          if (xfer_start && xfer_valid) begin
            state         <= ACCESS;
            bus.HREADYOUT <= 1'b0;
            bus.HRESP     <= HRESP_OKAY;
            bus.be_req    <= 1'b1;
            bus.be_write  <= bus.HWRITE;
            bus.be_addr   <= bus.HADDR[7:0];
            cnt           <= '0;
          end else if (xfer_start) begin
            state         <= ERR1;
            bus.HREADYOUT <= 1'b0;
            bus.HRESP     <= HRESP_ERROR;
          end else begin
            state         <= IDLE;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= HRESP_OKAY;
          end
        end
        ACCESS: begin
          // An ack in the last allowed cycle still completes normally.
          if (bus.be_ack) begin
            state         <= DONE;
            bus.HREADYOUT <= 1'b1;
            bus.be_req    <= 1'b0;
            if (!bus.be_write) bus.HRDATA <= bus.be_rdata;
          end else if (cnt == CNT_LAST) begin
            state         <= ERR1;
            bus.HRESP     <= HRESP_ERROR;
            bus.be_req    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ERR1: begin
          state         <= ERR2;
          bus.HREADYOUT <= 1'b1;
          bus.HRESP     <= HRESP_ERROR;
        end
        default: begin
          state         <= IDLE;
          bus.HREADYOUT <= 1'b1;
          bus.HRESP     <= HRESP_OKAY;
          bus.be_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sensor_ctrl.sv
// Self-checking bench for ahb_sensor_ctrl: directed scenarios plus randomized traffic vs a transfer-level model.
module tb_ahb_sensor_ctrl;
  import ahb_pkg::*;

  localparam logic [31:0] BASE    = 32'hF0F0_F0F0;
  localparam logic [31:0] MASK    = 32'hFFFF_FF00;
  localparam int          TIMEOUT = 16;

  logic        HCLK;
  logic        HRESET;
  ctrl_state_t state;

  int vectors     = 0;
  int miscompares = 0;

  ahb_sensor_ctrl_if #(.DATA_W(128)) bus ();

  ahb_sensor_ctrl #(
    .BASE_ADDR (BASE),
    .ADDR_MASK (MASK),
    .DATA_W    (128),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus),
    .state  (state)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- transfer-level model ----------------
  // m_acc: a data phase is waiting on the backend for m_age cycles so far.
  // m_err: cycles of ERROR response still to show (2 = first, 1 = second).
  logic         model_ok = 1'b0;
  logic         m_acc, m_done, m_bw, m_rd_done;
  int           m_age, m_err;
  logic [7:0]   m_ba;
  logic [127:0] m_hrdata;
  logic [127:0] exp_q[$];
  logic         m_start, m_valid;

  always @(posedge HCLK) begin
    m_rd_done = 1'b0;
    if (HRESET) begin
      m_acc = 0; m_age = 0; m_err = 0; m_done = 0; m_bw = 0; m_ba = 0;
      m_hrdata = '0; exp_q.delete(); model_ok = 1'b1;
    end else if (m_acc) begin
      if (bus.be_ack) begin
        m_acc = 0; m_done = 1;
        if (!m_bw) begin
          m_hrdata = bus.be_rdata; exp_q.push_back(bus.be_rdata); m_rd_done = 1'b1;
        end
      end else if (m_age == TIMEOUT - 1) begin
        m_acc = 0; m_err = 2;
      end else begin
        m_age++;
      end
    end else if (m_err == 2) begin
      m_err = 1;
    end else begin
      m_err = 0; m_done = 0;
      m_start = bus.HSELx && bus.HREADY && bus.HTRANS[1];
      m_valid = ((bus.HADDR & MASK) == (BASE & MASK)) && (bus.HBURST == 3'b000) &&
                (bus.HSIZE == 3'b100) && (bus.HTRANS == 2'b10);
      if (m_start && m_valid) begin
        m_acc = 1; m_age = 0; m_bw = bus.HWRITE; m_ba = bus.HADDR[7:0];
      end else if (m_start) begin
        m_err = 2;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_state_t model_state();
    if (m_acc)           return ACCESS;
    else if (m_err == 2) return ERR1;
    else if (m_err == 1) return ERR2;
    else if (m_done)     return DONE;
    else                 return IDLE;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge HCLK) begin
    if (model_ok) begin
      chk("hreadyout", 128'(bus.HREADYOUT), 128'(!m_acc && m_err != 2));
      chk("hresp",     128'(bus.HRESP),     128'(m_err != 0));
      chk("be_req",    128'(bus.be_req),    128'(m_acc));
      chk("be_write",  128'(bus.be_write),  128'(m_bw));
      chk("be_addr",   128'(bus.be_addr),   128'(m_ba));
      chk("hrdata",    bus.HRDATA,          m_hrdata);
      chk("state",     128'(state),         128'(model_state()));
      if (m_acc) chk("be_wdata", bus.be_wdata, bus.HWDATA);
      if (m_rd_done && exp_q.size() > 0) chk("rd_scoreboard", bus.HRDATA, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    bus.HSELx  = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HREADY = 1'b1;
    bus.be_ack = 1'b0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [1:0] t, input logic w,
                            input logic [2:0] s, input logic [2:0] b);
    bus.HSELx = 1'b1; bus.HREADY = 1'b1; bus.HADDR = a; bus.HTRANS = t;
    bus.HWRITE = w; bus.HSIZE = s; bus.HBURST = b;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] inv_addr  [4] = '{BASE, BASE, BASE, 32'h0000_0000};
  logic [1:0]  inv_trans [4] = '{2'b10, 2'b10, 2'b11, 2'b10};
  logic [2:0]  inv_size  [4] = '{3'b100, 3'b010, 3'b100, 3'b100};
  logic [2:0]  inv_burst [4] = '{3'b010, 3'b000, 3'b000, 3'b000};

  initial begin
    int n;
    int r;
    HRESET = 1'b1;
    bus_idle();
    bus.HADDR = '0; bus.HWRITE = 0; bus.HSIZE = HSIZE_128; bus.HBURST = HBURST_SINGLE;
    bus.HWDATA = '0; bus.be_rdata = '0;

    // Reset held for two cycles.
    tick(); tick();
    chk("rst_hreadyout", 128'(bus.HREADYOUT), 128'd1);
    chk("rst_hresp",     128'(bus.HRESP),     128'd0);
    chk("rst_be_req",    128'(bus.be_req),    128'd0);
    chk("rst_hrdata",    bus.HRDATA,          128'd0);
    HRESET = 1'b0;
    tick();

    // Valid read with ack in the third wait cycle.
    addr_phase(BASE, HTRANS_NONSEQ, 1'b0, HSIZE_128, HBURST_SINGLE);
    tick(); bus_idle();
    n = 0;
    while (bus.HREADYOUT == 1'b0 && n < 50) begin
      if (n == 2) begin bus.be_ack = 1'b1; bus.be_rdata = 128'hDEAD_BEEF; end
      tick(); bus.be_ack = 1'b0; n++;
    end
    chk("read_wait_cycles", 128'(n), 128'd3);
    chk("read_hrdata", bus.HRDATA, 128'hDEAD_BEEF);
    chk("read_hresp",  128'(bus.HRESP), 128'd0);
    tick();

    // Write with immediate ack, then a read sampled in DONE.
    addr_phase(BASE + 32'd4, HTRANS_NONSEQ, 1'b1, HSIZE_128, HBURST_SINGLE);
    tick(); bus_idle();
    bus.HWDATA = 128'h1234; bus.be_ack = 1'b1;
    chk("wr_be_wdata", bus.be_wdata, 128'h1234);
    chk("wr_be_write", 128'(bus.be_write), 128'd1);
    chk("wr_be_addr",  128'(bus.be_addr), 128'hF4);
    tick(); bus.be_ack = 1'b0;
    chk("wr_done_ready", 128'(bus.HREADYOUT), 128'd1);
    addr_phase(BASE + 32'd8, HTRANS_NONSEQ, 1'b0, HSIZE_128, HBURST_SINGLE);
    tick(); bus_idle();
    chk("b2b_be_req",   128'(bus.be_req), 128'd1);
    chk("b2b_be_write", 128'(bus.be_write), 128'd0);
    chk("b2b_be_addr",  128'(bus.be_addr), 128'hF8);
    bus.be_ack = 1'b1; bus.be_rdata = 128'hCAFE;
    tick(); bus.be_ack = 1'b0;
    chk("b2b_hrdata", bus.HRDATA, 128'hCAFE);
    tick();

    // Invalid transfers: two-cycle ERROR, backend untouched.
    for (int i = 0; i < 4; i++) begin
      addr_phase(inv_addr[i], inv_trans[i], 1'b0, inv_size[i], inv_burst[i]);
      tick(); bus_idle();
      chk("err1_ready",  128'(bus.HREADYOUT), 128'd0);
      chk("err1_resp",   128'(bus.HRESP), 128'd1);
      chk("err1_be_req", 128'(bus.be_req), 128'd0);
      tick();
      chk("err2_ready",  128'(bus.HREADYOUT), 128'd1);
      chk("err2_resp",   128'(bus.HRESP), 128'd1);
      tick();
    end

    // Timeout: no ack at all.
    addr_phase(BASE, HTRANS_NONSEQ, 1'b0, HSIZE_128, HBURST_SINGLE);
    tick(); bus_idle();
    n = 0;
    while (bus.be_req && n < 100) begin tick(); n++; end
    chk("tmo_req_cycles", 128'(n), 128'd16);
    chk("tmo_err1_ready", 128'(bus.HREADYOUT), 128'd0);
    chk("tmo_err1_resp",  128'(bus.HRESP), 128'd1);
    tick();
    chk("tmo_err2_ready", 128'(bus.HREADYOUT), 128'd1);
    chk("tmo_err2_resp",  128'(bus.HRESP), 128'd1);
    tick();

    // Ack arriving in the timeout cycle wins.
    addr_phase(BASE, HTRANS_NONSEQ, 1'b0, HSIZE_128, HBURST_SINGLE);
    tick(); bus_idle();
    n = 0;
    while (bus.be_req && n < 100) begin
      if (n == 15) begin bus.be_ack = 1'b1; bus.be_rdata = 128'hBEEF01; end
      tick(); bus.be_ack = 1'b0; n++;
    end
    chk("late_ack_cycles", 128'(n), 128'd16);
    chk("late_ack_resp",   128'(bus.HRESP), 128'd0);
    chk("late_ack_ready",  128'(bus.HREADYOUT), 128'd1);
    chk("late_ack_hrdata", bus.HRDATA, 128'hBEEF01);
    tick();

    // Reset in the second wait cycle, then a stray ack.
    addr_phase(BASE, HTRANS_NONSEQ, 1'b0, HSIZE_128, HBURST_SINGLE);
    tick(); bus_idle();
    tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    chk("mid_rst_be_req", 128'(bus.be_req), 128'd0);
    chk("mid_rst_ready",  128'(bus.HREADYOUT), 128'd1);
    bus.be_ack = 1'b1; bus.be_rdata = 128'h5555;
    tick(); bus.be_ack = 1'b0;
    chk("stray_ack_hrdata", bus.HRDATA, 128'd0);
    chk("stray_ack_state",  128'(state), 128'(IDLE));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      HRESET     = ($urandom_range(0, 199) == 0);
      bus.HSELx  = ($urandom_range(0, 3) != 0);
      bus.HREADY = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 7);
      bus.HTRANS = (r == 0) ? HTRANS_IDLE : (r == 1) ? HTRANS_BUSY :
                   (r == 2) ? HTRANS_SEQ : HTRANS_NONSEQ;
      bus.HADDR  = ($urandom_range(0, 3) == 0) ? $urandom
                                                : {BASE[31:8], 8'($urandom_range(0, 255))};
      bus.HSIZE  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : HSIZE_128;
      bus.HBURST = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : HBURST_SINGLE;
      bus.HWRITE = 1'($urandom_range(0, 1));
      bus.HWDATA = rnd128();
      bus.be_ack = ($urandom_range(0, 5) == 0);
      bus.be_rdata = rnd128();
      tick();
    end

    HRESET = 1'b0;
    bus_idle();
    repeat (TIMEOUT + 4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
